// File: rtl/i2c_result_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : i2c_uart_pkg
// Purpose : Shared encodings, status byte layout and helper functions for the
//           I2C-result to UART transmit arbiter.
// Contents: in_kind encodings, op one-hot constants, op2 encodings, status_t,
//           output-slot state type, compact_fail(), op_to_op2().
// Revision: 1.0 - initial release
// ============================================================================
package i2c_uart_pkg;

  // in_kind encodings
  localparam logic [1:0] KIND_DEF   = 2'b01;
  localparam logic [1:0] KIND_INSTR = 2'b11;

  // Operation one-hot inputs
  localparam logic [3:0] OP_RD1 = 4'b0001;
  localparam logic [3:0] OP_RD2 = 4'b0010;
  localparam logic [3:0] OP_WR1 = 4'b0100;
  localparam logic [3:0] OP_WR2 = 4'b1000;

  // Compact 2-bit operation codes carried in the status byte
  localparam logic [1:0] OP2_RD1 = 2'b00;
  localparam logic [1:0] OP2_RD2 = 2'b01;
  localparam logic [1:0] OP2_WR1 = 2'b10;
  localparam logic [1:0] OP2_WR2 = 2'b11;

  typedef struct packed {
    logic [5:0] fail6;
    logic [1:0] op2;
  } status_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } out_state_t;

  // Bits 6 and 2 both report bus-level faults and share one status bit.
  function automatic logic [5:0] compact_fail(input logic [6:0] f);
    return {f[6] | f[2], f[5:3], f[1:0]};
  endfunction

  // Anything that is not exactly one-hot falls back to rd1.
  function automatic logic [1:0] op_to_op2(input logic [3:0] op);
    case (op)
      OP_RD1:  return OP2_RD1;
      OP_RD2:  return OP2_RD2;
      OP_WR1:  return OP2_WR1;
      OP_WR2:  return OP2_WR2;
      default: return OP2_RD1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_result_tx_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module  : result_fifo
// Purpose : Record FIFO for instruction results with registered level/flags.
// Ports   : clk, rst_n (async active-low), push/wr_data, pop/rd_data
//           (head is read combinationally), level, full, empty, almost_full.
// Revision: 1.0 - initial release
// ============================================================================
module result_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int AFULL_LVL = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic             push_ok;
  logic             pop_ok;

  // Guard locally so a misbehaving caller cannot corrupt the pointers.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (push_ok && !pop_ok) begin
      level_nxt = level + LVL_W'(1);
    end else if (pop_ok && !push_ok) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  // Storage carries no reset; validity is tracked by the level counter.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      level       <= level_nxt;
      full        <= (level_nxt == LVL_W'(DEPTH));
      empty       <= (level_nxt == '0);
      almost_full <= (level_nxt >= LVL_W'(AFULL_LVL));
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_result_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : i2c_result_tx_arbiter
// Purpose : Queues I2C instruction results in a FIFO, keeps the newest default
//           read in a latest-value slot and presents one record at a time to
//           the UART over valid/ready, bounding default-read starvation.
// Ports   : clk, reset (async active-low)
//           in_valid/in_kind/in_data/in_addr/in_op/in_fail  - I2C results
//           out_valid/out_ready/out_data/out_addr/out_status - UART side
//           fifo_level/fifo_full/fifo_empty/almost_full      - FIFO status
//           overflow (sticky), drop_count (saturating)
// Revision: 1.0 - initial release
// ============================================================================
module i2c_result_tx_arbiter
  import i2c_uart_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int STARVE_LIM = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [1:0]                 in_kind,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [7:0]                 in_op,
  input  logic [6:0]                 in_fail,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [7:0]                 out_status,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       almost_full,
  output logic                       overflow,
  output logic [15:0]                drop_count
);

  localparam int REC_W = DATA_W + ADDR_W + 8;
  localparam int SC_W  = $clog2(STARVE_LIM + 1);

  out_state_t        state;
  status_t           instr_status;
  logic [REC_W-1:0]  rec_in;
  logic [REC_W-1:0]  head;
  logic [DATA_W-1:0] latest_data;
  status_t           latest_status;
  logic              pend;
  logic [SC_W-1:0]   starve_cnt;

  logic instr_in, def_in, push, starved, take_fifo, take_latest;
  logic slot_free, load, pop, consume;

  assign instr_in     = in_valid && (in_kind == KIND_INSTR);
  assign def_in       = in_valid && (in_kind == KIND_DEF);
  assign push         = instr_in && !fifo_full;
  assign instr_status = {compact_fail(in_fail), op_to_op2(in_op[3:0])};
  assign rec_in       = {in_data, in_addr, instr_status};

  // The FIFO wins unless it is empty or the pending default read has been
  // passed over STARVE_LIM times in a row.
  assign starved     = pend && (starve_cnt == SC_W'(STARVE_LIM));
  assign take_fifo   = !fifo_empty && !starved;
  assign take_latest = pend && !take_fifo;
  assign slot_free   = !out_valid || out_ready;
  assign load        = slot_free && (take_fifo || take_latest);
  assign pop         = load && take_fifo;
  assign consume     = load && take_latest;

  result_fifo #(
    .WIDTH     (REC_W),
    .DEPTH     (DEPTH),
    .AFULL_LVL (AFULL_LVL)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push        (push),
    .wr_data     (rec_in),
    .pop         (pop),
    .rd_data     (head),
    .level       (fifo_level),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .almost_full (almost_full)
  );

  // Latest-value slot, starvation counter, drop counter and overflow flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latest_data   <= '0;
      latest_status <= '0;
      pend          <= 1'b0;
      starve_cnt    <= '0;
      drop_count    <= '0;
      overflow      <= 1'b0;
    end else begin
      if (instr_in && fifo_full) overflow <= 1'b1;

      if (def_in) begin
        latest_data   <= in_data;
        latest_status <= {compact_fail(in_fail), OP2_RD2};
        // A fresh value arriving as the old one is taken out is a refill.
        pend          <= 1'b1;
        if (pend && !consume && (drop_count != 16'hFFFF)) begin
          drop_count <= drop_count + 16'd1;
        end
      end else if (consume) begin
        pend <= 1'b0;
      end

      if (!pend || consume) begin
        starve_cnt <= '0;
      end else if (pop) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end
    end
  end

  // Output slot: out_valid is high exactly in HOLD, and the record registers
  // only move on a load, so they stay frozen while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_addr   <= '0;
      out_status <= '0;
    end else begin
      if (load) begin
        state     <= S_HOLD;
        out_valid <= 1'b1;
        if (take_fifo) begin
          out_data   <= head[REC_W-1 -: DATA_W];
          out_addr   <= head[8 +: ADDR_W];
          out_status <= head[7:0];
        end else begin
          out_data   <= latest_data;
          out_addr   <= '0;
          out_status <= latest_status;
        end
      end else if (state == S_HOLD && out_ready) begin
        state     <= S_IDLE;
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_result_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_result_tx_arbiter
// Purpose : Directed self-checking bench for i2c_result_tx_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_i2c_result_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_kind = 2'b00;
  logic [15:0] in_data = '0;
  logic [7:0]  in_addr = '0;
  logic [7:0]  in_op = '0;
  logic [6:0]  in_fail = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic [7:0]  out_addr;
  logic [7:0]  out_status;
  logic [3:0]  fifo_level;
  logic        fifo_full, fifo_empty, almost_full, overflow;
  logic [15:0] drop_count;

  int total = 0;
  int passed = 0;

  i2c_result_tx_arbiter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_kind(in_kind),
    .in_data(in_data), .in_addr(in_addr), .in_op(in_op), .in_fail(in_fail),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_status(out_status), .fifo_level(fifo_level),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .almost_full(almost_full),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [15:0] d, input logic [7:0] a,
                           input logic [3:0] op, input logic [6:0] f);
    in_valid = 1'b1; in_kind = 2'b11; in_data = d; in_addr = a;
    in_op = {4'b0, op}; in_fail = f;
  endtask

  task automatic set_def(input logic [15:0] d);
    in_valid = 1'b1; in_kind = 2'b01; in_data = d; in_addr = 8'h00;
    in_op = 8'h00; in_fail = 7'h00;
  endtask

  task automatic clear_in;
    in_valid = 1'b0; in_kind = 2'b00;
  endtask

  task automatic test_reset;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0h exp 0", out_valid); else passed++;
    total++; if (out_data !== 16'h0) $display("FAIL rst_out_data: got %h exp 0000", out_data); else passed++;
    total++; if (fifo_level !== 4'd0) $display("FAIL rst_level: got %0d exp 0", fifo_level); else passed++;
    total++; if (fifo_empty !== 1'b1) $display("FAIL rst_empty: got %0h exp 1", fifo_empty); else passed++;
    total++; if ({fifo_full, almost_full, overflow} !== 3'b000) $display("FAIL rst_flags: got %b exp 000", {fifo_full, almost_full, overflow}); else passed++;
    total++; if (drop_count !== 16'h0) $display("FAIL rst_drop: got %0d exp 0", drop_count); else passed++;
  endtask

  task automatic test_single;
    out_ready = 1'b1;
    set_instr(16'h1A2B, 8'h48, 4'b0010, 7'h00);
    tick; clear_in;
    total++; if (out_valid !== 1'b0) $display("FAIL single_t1_valid: got %0h exp 0", out_valid); else passed++;
    tick;
    total++; if (out_valid !== 1'b1) $display("FAIL single_t2_valid: got %0h exp 1", out_valid); else passed++;
    total++; if (out_data !== 16'h1A2B) $display("FAIL single_data: got %h exp 1a2b", out_data); else passed++;
    total++; if (out_addr !== 8'h48) $display("FAIL single_addr: got %h exp 48", out_addr); else passed++;
    total++; if (out_status !== 8'h01) $display("FAIL single_status: got %h exp 01", out_status); else passed++;
    tick;
    total++; if (out_valid !== 1'b0) $display("FAIL single_idle: got %0h exp 0", out_valid); else passed++;
  endtask

  task automatic test_failure_map;
    set_instr(16'h5555, 8'h10, 4'b1000, 7'b1000100);
    tick; clear_in; tick;
    total++; if (out_status !== 8'b1000_0011) $display("FAIL fail_map_status: got %b exp 10000011", out_status); else passed++;
    set_instr(16'h6666, 8'h11, 4'b0110, 7'b0101011);
    tick; clear_in; tick;
    total++; if (out_status !== 8'b0101_1100) $display("FAIL fail_map_nonhot: got %b exp 01011100", out_status); else passed++;
    tick;
  endtask

  task automatic test_default_overwrite;
    out_ready = 1'b0;
    set_instr(16'h1111, 8'h22, 4'b0001, 7'h00);
    tick; clear_in; tick;
    set_def(16'hD001); tick;
    set_def(16'hD002); tick;
    set_def(16'hD003); tick;
    clear_in;
    total++; if (drop_count !== 16'd2) $display("FAIL ovw_drop: got %0d exp 2", drop_count); else passed++;
    total++; if (out_data !== 16'h1111) $display("FAIL ovw_frozen: got %h exp 1111", out_data); else passed++;
    out_ready = 1'b1;
    tick;
    total++; if ({out_valid, out_data, out_addr, out_status} !== {1'b1, 16'hD003, 8'h00, 8'h01})
      $display("FAIL ovw_sent: got %0h/%h/%h/%h exp 1/d003/00/01", out_valid, out_data, out_addr, out_status); else passed++;
    tick;
    total++; if (out_valid !== 1'b0) $display("FAIL ovw_idle: got %0h exp 0", out_valid); else passed++;
  endtask

  task automatic test_starvation;
    logic [15:0] exp_seq [7];
    exp_seq = '{16'h0101, 16'h0102, 16'h0103, 16'h0104, 16'hDEF0, 16'h0105, 16'h0106};
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      set_instr(16'h0100 + 16'(i), 8'(i), 4'b0001, 7'h00);
      tick;
    end
    set_def(16'hDEF0); tick; clear_in;
    total++; if (fifo_level !== 4'd6) $display("FAIL starve_level: got %0d exp 6", fifo_level); else passed++;
    total++; if (out_data !== 16'h0100) $display("FAIL starve_held: got %h exp 0100", out_data); else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick;
      total++; if (out_valid !== 1'b1 || out_data !== exp_seq[i])
        $display("FAIL starve_seq%0d: got %0h/%h exp 1/%h", i, out_valid, out_data, exp_seq[i]); else passed++;
    end
    tick;
    total++; if (out_valid !== 1'b0) $display("FAIL starve_idle: got %0h exp 0", out_valid); else passed++;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) set_instr(16'hB000 + 16'(k), 8'hB0, 4'b0100, 7'h00);
      else clear_in;
      tick;
      if (k >= 1 && k <= 4) begin
        total++; if (out_valid !== 1'b1 || out_data !== 16'hB000 + 16'(k - 1))
          $display("FAIL b2b_rec%0d: got %0h/%h exp 1/%h", k - 1, out_valid, out_data, 16'hB000 + 16'(k - 1)); else passed++;
      end
      if (k == 5) begin
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_idle: got %0h exp 0", out_valid); else passed++;
      end
    end
  endtask

  task automatic test_fill_overflow;
    out_ready = 1'b0;
    set_instr(16'h2000, 8'h20, 4'b0001, 7'h00);
    tick; clear_in; tick;
    for (int k = 1; k <= 8; k++) begin
      set_instr(16'h2000 + 16'(k), 8'h20, 4'b0001, 7'h00);
      tick;
      if (k == 5) begin
        total++; if ({fifo_level, almost_full} !== {4'd5, 1'b0}) $display("FAIL fill_lvl5: got %0d/%0h exp 5/0", fifo_level, almost_full); else passed++;
      end
      if (k == 6) begin
        total++; if (almost_full !== 1'b1) $display("FAIL fill_afull6: got %0h exp 1", almost_full); else passed++;
      end
    end
    clear_in;
    total++; if ({fifo_full, fifo_level} !== {1'b1, 4'd8}) $display("FAIL fill_full: got %0h/%0d exp 1/8", fifo_full, fifo_level); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL fill_no_ovf: got %0h exp 0", overflow); else passed++;
    set_instr(16'h2009, 8'h20, 4'b0001, 7'h00); tick; clear_in;
    total++; if ({overflow, fifo_level} !== {1'b1, 4'd8}) $display("FAIL ovf_set: got %0h/%0d exp 1/8", overflow, fifo_level); else passed++;
    // Refused write coincident with a pop
    set_instr(16'h20AA, 8'h20, 4'b0001, 7'h00); out_ready = 1'b1; tick; clear_in;
    total++; if ({overflow, fifo_level, out_data} !== {1'b1, 4'd7, 16'h2001})
      $display("FAIL ovf_pop: got %0h/%0d/%h exp 1/7/2001", overflow, fifo_level, out_data); else passed++;
  endtask

  task automatic test_reset_mid_hold;
    repeat (4) tick;
    out_ready = 1'b0;
    tick;
    total++; if ({out_valid, fifo_level, out_data} !== {1'b1, 4'd3, 16'h2005})
      $display("FAIL rmh_pre: got %0h/%0d/%h exp 1/3/2005", out_valid, fifo_level, out_data); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if ({out_valid, out_data, out_addr, out_status} !== '0)
      $display("FAIL rmh_out: got %0h/%h/%h/%h exp 0/0/0/0", out_valid, out_data, out_addr, out_status); else passed++;
    total++; if ({fifo_level, fifo_empty, fifo_full, almost_full} !== {4'd0, 1'b1, 1'b0, 1'b0})
      $display("FAIL rmh_fifo: got %0d/%0h/%0h/%0h exp 0/1/0/0", fifo_level, fifo_empty, fifo_full, almost_full); else passed++;
    total++; if ({overflow, drop_count} !== {1'b0, 16'h0}) $display("FAIL rmh_sticky: got %0h/%0d exp 0/0", overflow, drop_count); else passed++;
    @(posedge clk); #1 reset = 1'b1;
    tick;
    total++; if ({fifo_empty, out_valid} !== 2'b10) $display("FAIL rmh_after: got %b exp 10", {fifo_empty, out_valid}); else passed++;
  endtask

  initial begin
    repeat (2) tick;
    test_reset;
    reset = 1'b1;
    tick;
    test_single;
    test_failure_map;
    test_default_overwrite;
    test_starvation;
    test_back_to_back;
    test_fill_overflow;
    test_reset_mid_hold;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_result_tx_arbiter.md
# i2c_result_tx_arbiter

Parametrised successor to the I2C-to-UART result arbiter. Sits between the I2C controller and the UART transmitter. It queues PC-instruction results in a single record FIFO and keeps the most recent default temperature read in a one-entry latest-value slot. It then presents one record at a time to the UART over a valid/ready handshake, with bounded starvation of default reads.

## Interface
- DATA_W, 16: width of retrieved I2C data.
- ADDR_W, 8: width of instruction register address.
- DEPTH, 8: instruction-result FIFO depth; power of two, at least 2.
- AFULL_LVL, DEPTH-2: fifo_level at or above which almost_full asserts.
- STARVE_LIM, 4: consecutive FIFO transmissions allowed while a default read is pending.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  I2C result strobe, one cycle per result.
- in_kind  in  2  2'b01 = default read, 2'b11 = PC instruction; other values are ignored.
- in_data  in  DATA_W  retrieved data.
- in_addr  in  ADDR_W  instruction address.
- in_op  in  8  operation one-hot in [3:0]: rd1, rd2, wr1, wr2.
- in_fail  in  7  failure flags.
- out_valid  out  1  record presented to the UART.
- out_ready  in  1  UART accepts the record.
- out_data  out  DATA_W  record data.
- out_addr  out  ADDR_W  record address; 0 for default reads.
- out_status  out  8  status byte: {fail6, op2}.
- fifo_level  out  $clog2(DEPTH+1)  number of queued instruction records.
- fifo_full, fifo_empty, almost_full  out  1  FIFO flags, registered.
- overflow  out  1  sticky flag: instruction write arrived while the FIFO was full.
- drop_count  out  16  saturating count of default reads overwritten before they were sent.

## Operation
- Accepted instruction result: in_valid && in_kind==2'b11 && !fifo_full. The record {data, addr, status} is pushed.
- Write while fifo_full is refused and sets overflow, even if a pop happens in the same cycle. overflow clears only on reset.
- Default read: in_valid && in_kind==2'b01. Written into the latest slot, which sets pend.
- If pend was already set and the slot is not being consumed in that cycle, drop_count increments. It saturates at 16'hFFFF.
- Status byte:
  - op2 is rd1=00, rd2=01, wr1=10, wr2=11; any non-one-hot value maps to 00.
  - fail6 = {f[6]|f[2], f[5:3], f[1:0]}.
  - Default reads always use op2=01.
- Output slot has two states, IDLE and HOLD:
  - IDLE -> HOLD when a source is available; the record is loaded into the output register.
  - In HOLD, outputs are frozen while out_valid && !out_ready.
  - On handshake: reload the same cycle if a source is available, otherwise go to IDLE.
- Source selection on load:
  - FIFO head is chosen unless the FIFO is empty, or pend is set and starve_cnt==STARVE_LIM.
  - starve_cnt increments on each FIFO load while pend is set. It clears on a latest-slot load or when pend is clear.
- Default read arriving in the same cycle the latest slot is loaded into the output: the new value refills the slot, pend stays 1, and there is no drop.
- Push and pop in the same cycle leave fifo_level unchanged. Pointers wrap modulo DEPTH.

## Timing
- Reset values (asynchronous, active-low):
  - out_valid=0 and out_data/out_addr/out_status=0.
  - fifo_level=0, fifo_empty=1, fifo_full=0, almost_full=0.
  - overflow=0, drop_count=0, pend=0, starve_cnt=0, state IDLE.
- Reset asserted mid-transfer discards all queued and pending records.
- Latency from in_valid at cycle t with an idle output: out_valid at t+2 on both paths (registered store, then output load).
- Back-to-back: with out_ready held high, one record per cycle is sustained.
- Flags and fifo_level update the cycle after the push or pop.
- out_* never change while out_valid && !out_ready.

## Structure
- Package i2c_uart_pkg holds:
  - in_kind encodings (KIND_DEF, KIND_INSTR).
  - op one-hot constants and the op2 encodings.
  - A packed status_t struct {fail6, op2}.
  - Function compact_fail(7b) -> 6b.
- Sub-module result_fifo: parametrised by width and DEPTH, asynchronous active-low reset. It stores the packed record of DATA_W+ADDR_W+8 bits and provides level, full, empty and almost_full.
- Top level holds the latest slot, the output FSM, the starvation counter and the drop counter.

## Test plan
- Single instruction: in_data=16'h1A2B, addr=8'h48, op=4'b0010, fail=0, with out_ready=1. Expect out_valid at t+2 with out_status=8'h01, then IDLE.
- Fill and overflow with DEPTH=8 and out_ready=0:
  - After 8 instruction writes: fifo_full=1, almost_full already high at level 6.
  - A 9th write sets overflow=1 and fifo_level stays 8.
- Default overwrite with out_ready=0 and the output already holding a record: three default reads. Expect drop_count=2 and that the last value is the one sent.
- Starvation with STARVE_LIM=4: FIFO holding 6 records, pend=1, out_ready=1. Sends follow the order FIFO×4, default, FIFO×2.
- Failure mapping: in_fail=7'b1000100, op=4'b1000. Expect out_status=8'b1000_0011.
- Reset mid-HOLD with 3 records queued: all outputs return to reset values asynchronously, and after release fifo_empty=1.
